// File: rtl/ulpi_tx_arbiter_pkg.sv
// ulpi_tx_arbiter_pkg
//   Shared definitions for the ULPI transmit arbiter: FSM state encoding,
//   grant codes, USB handshake PID values and the watchdog counter width.
//   No ports (package).
package ulpi_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HSK   = 3'd1,
    ST_REGW  = 3'd2,
    ST_DATA  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_WAIT  = 3'd5
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_HSK  = 2'd1;
  localparam logic [1:0] GNT_REG  = 2'd2;
  localparam logic [1:0] GNT_DATA = 2'd3;

  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;

  localparam int WD_W = 10;

  // States in which the encoder owns a transaction and the watchdog runs.
  function automatic logic wd_active(arb_state_t s);
    return (s == ST_HSK) || (s == ST_REGW) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/ulpi_tick_timer.sv
// ulpi_tick_timer
//   Loadable down-counter that saturates at zero.
//   clock, reset  : clock and asynchronous active-high reset
//   load          : load load_value (has priority over enable)
//   load_value    : value loaded on load
//   enable        : decrement by one while nonzero
//   zero          : count is zero
module ulpi_tick_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ulpi_tx_arbiter.sv
// ulpi_tx_arbiter
//   Shares one ULPI transmit encoder between the handshake issuer, the PHY
//   register-write sequencer and the IN-data stream, with an inter-packet gap
//   and a per-transaction watchdog.
//   clock, reset            : 60 MHz ULPI clock, async active-high reset
//   high_speed_i            : register writes are only granted while low
//   reg_req/addr/data/ack   : register-write requester
//   hsk_req/pid/ack         : handshake requester
//   s_t*                    : IN-data AXI-S sink, dat_done_o on packet end
//   enc_phy_* / enc_hsk_*   : encoder control strobes and completions
//   enc_usb_busy/done_i     : encoder line activity / data packet completion
//   m_t*                    : AXI-S towards the encoder
//   grant_o                 : 0 none, 1 hsk, 2 reg, 3 data
//   timeout_o               : watchdog expired pulse
//
//   state | meaning
//   IDLE  | arbitrate pending requests
//   HSK   | handshake PID presented, enc_hsk_send_o high
//   REGW  | register write presented, enc_phy_write_o high
//   DATA  | stream passes through to the encoder
//   FLUSH | watchdog fired during DATA, discard beats up to tlast
//   WAIT  | inter-packet gap, counts only while the encoder is not busy
module ulpi_tx_arbiter
  import ulpi_tx_arbiter_pkg::*;
#(
  parameter int IPG_CYCLES = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       high_speed_i,
  input  logic       reg_req_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] reg_data_i,
  output logic       reg_ack_o,
  input  logic       hsk_req_i,
  input  logic [3:0] hsk_pid_i,
  output logic       hsk_ack_o,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tkeep,
  input  logic       s_tlast,
  input  logic [3:0] s_tuser,
  input  logic [7:0] s_tdata,
  output logic       dat_done_o,
  output logic       enc_phy_write_o,
  output logic [7:0] enc_phy_addr_o,
  output logic [7:0] enc_phy_data_o,
  input  logic       enc_phy_done_i,
  output logic       enc_hsk_send_o,
  input  logic       enc_hsk_done_i,
  input  logic       enc_usb_busy_i,
  input  logic       enc_usb_done_i,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tkeep,
  output logic       m_tlast,
  output logic [3:0] m_tuser,
  output logic [7:0] m_tdata,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  localparam int IPG_W = $clog2(IPG_CYCLES + 1);
  localparam logic [IPG_W-1:0] IPG_LOAD = IPG_W'(IPG_CYCLES);
  // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th active cycle.
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);

  arb_state_t state;
  logic [3:0] hsk_pid_q;
  logic       ipg_zero;
  logic       wd_zero;

  // Both timers are held at their load value outside the states they time,
  // so they start fresh on every entry without a next-state decode.
  ulpi_tick_timer #(.WIDTH(IPG_W)) u_ipg_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (state != ST_WAIT),
    .load_value (IPG_LOAD),
    .enable     (!enc_usb_busy_i),
    .zero       (ipg_zero)
  );

  ulpi_tick_timer #(.WIDTH(WD_W)) u_wd_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (!wd_active(state)),
    .load_value (WD_LOAD),
    .enable     (1'b1),
    .zero       (wd_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      grant_o         <= GNT_NONE;
      hsk_pid_q       <= 4'h0;
      enc_hsk_send_o  <= 1'b0;
      enc_phy_write_o <= 1'b0;
      enc_phy_addr_o  <= 8'h00;
      enc_phy_data_o  <= 8'h00;
      hsk_ack_o       <= 1'b0;
      reg_ack_o       <= 1'b0;
      dat_done_o      <= 1'b0;
      timeout_o       <= 1'b0;
    end else begin
      hsk_ack_o  <= 1'b0;
      reg_ack_o  <= 1'b0;
      dat_done_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hsk_req_i) begin
            state          <= ST_HSK;
            grant_o        <= GNT_HSK;
            hsk_pid_q      <= hsk_pid_i;
            enc_hsk_send_o <= 1'b1;
          end else if (reg_req_i && !high_speed_i) begin
            state           <= ST_REGW;
            grant_o         <= GNT_REG;
            enc_phy_addr_o  <= reg_addr_i;
            enc_phy_data_o  <= reg_data_i;
            enc_phy_write_o <= 1'b1;
          end else if (s_tvalid) begin
            state   <= ST_DATA;
            grant_o <= GNT_DATA;
          end
        end
        ST_HSK: begin
          if (enc_hsk_done_i) begin
            enc_hsk_send_o <= 1'b0;
            hsk_ack_o      <= 1'b1;
            grant_o        <= GNT_NONE;
            state          <= ST_WAIT;
          end else if (wd_zero) begin
            enc_hsk_send_o <= 1'b0;
            timeout_o      <= 1'b1;
            grant_o        <= GNT_NONE;
            state          <= ST_WAIT;
          end
        end
        ST_REGW: begin
          if (enc_phy_done_i) begin
            enc_phy_write_o <= 1'b0;
            reg_ack_o       <= 1'b1;
            grant_o         <= GNT_NONE;
            state           <= ST_WAIT;
          end else if (wd_zero) begin
            enc_phy_write_o <= 1'b0;
            timeout_o       <= 1'b1;
            grant_o         <= GNT_NONE;
            state           <= ST_WAIT;
          end
        end
        ST_DATA: begin
          if (enc_usb_done_i) begin
            dat_done_o <= 1'b1;
            grant_o    <= GNT_NONE;
            state      <= ST_WAIT;
          end else if (wd_zero) begin
            timeout_o <= 1'b1;
            state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (s_tvalid && s_tlast) begin
            dat_done_o <= 1'b1;
            grant_o    <= GNT_NONE;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ipg_zero) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_o <= GNT_NONE;
        end
      endcase
    end
  end

  // Stream path is combinational so DATA adds no latency or skid buffering.
  always_comb begin
    m_tvalid = 1'b0;
    m_tkeep  = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = 4'h0;
    m_tdata  = 8'h00;
    s_tready = 1'b0;
    case (state)
      ST_HSK: begin
        m_tuser = hsk_pid_q;
      end
      ST_DATA: begin
        m_tvalid = s_tvalid;
        m_tkeep  = s_tkeep;
        m_tlast  = s_tlast;
        m_tuser  = s_tuser;
        m_tdata  = s_tdata;
        s_tready = m_tready;
      end
      ST_FLUSH: begin
        s_tready = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ulpi_tx_arbiter.sv
module tb_ulpi_tx_arbiter;
  import ulpi_tx_arbiter_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       high_speed_i = 1'b0;
  logic       reg_req_i = 1'b0;
  logic [7:0] reg_addr_i = 8'h00;
  logic [7:0] reg_data_i = 8'h00;
  logic       reg_ack_o;
  logic       hsk_req_i = 1'b0;
  logic [3:0] hsk_pid_i = 4'h0;
  logic       hsk_ack_o;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tkeep = 1'b0;
  logic       s_tlast = 1'b0;
  logic [3:0] s_tuser = 4'h0;
  logic [7:0] s_tdata = 8'h00;
  logic       dat_done_o;
  logic       enc_phy_write_o;
  logic [7:0] enc_phy_addr_o;
  logic [7:0] enc_phy_data_o;
  logic       enc_phy_done_i = 1'b0;
  logic       enc_hsk_send_o;
  logic       enc_hsk_done_i = 1'b0;
  logic       enc_usb_busy_i = 1'b0;
  logic       enc_usb_done_i = 1'b0;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic       m_tkeep;
  logic       m_tlast;
  logic [3:0] m_tuser;
  logic [7:0] m_tdata;
  logic [1:0] grant_o;
  logic       timeout_o;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  ulpi_tx_arbiter #(.IPG_CYCLES(8), .TIMEOUT(1023)) dut (
    .clock(clock), .reset(reset), .high_speed_i(high_speed_i),
    .reg_req_i(reg_req_i), .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
    .reg_ack_o(reg_ack_o), .hsk_req_i(hsk_req_i), .hsk_pid_i(hsk_pid_i),
    .hsk_ack_o(hsk_ack_o), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tdata(s_tdata),
    .dat_done_o(dat_done_o), .enc_phy_write_o(enc_phy_write_o),
    .enc_phy_addr_o(enc_phy_addr_o), .enc_phy_data_o(enc_phy_data_o),
    .enc_phy_done_i(enc_phy_done_i), .enc_hsk_send_o(enc_hsk_send_o),
    .enc_hsk_done_i(enc_hsk_done_i), .enc_usb_busy_i(enc_usb_busy_i),
    .enc_usb_done_i(enc_usb_done_i), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tdata(m_tdata),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (dat_done_o) done_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] pkt [4];
  logic [7:0] rx [4];
  logic [3:0] rx_user;
  int beat;
  int gap;
  int cnt;
  int done_base;
  logic hs;
  logic seen;

  initial begin
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
    for (int i = 0; i < 4; i++) rx[i] = 8'h00;
    rx_user = 4'h0;

    // Reset state
    repeat (3) tick();
    check_val("rst_grant", grant_o, 0);
    check_val("rst_strobes", {hsk_ack_o, reg_ack_o, dat_done_o, timeout_o,
                              enc_hsk_send_o, enc_phy_write_o}, 0);
    check_val("rst_stream", {m_tvalid, s_tready, m_tdata, m_tuser}, 0);
    check_val("rst_phy", {enc_phy_addr_o, enc_phy_data_o}, 0);
    reset = 1'b0;
    tick();

    // Handshake, then IPG before the next grant
    hsk_req_i = 1'b1; hsk_pid_i = PID_ACK;
    tick();
    check_val("hsk_grant", grant_o, 1);
    check_val("hsk_send", enc_hsk_send_o, 1);
    check_val("hsk_tuser", m_tuser, 4'h2);
    check_val("hsk_mvalid", {m_tvalid, s_tready}, 0);
    repeat (3) tick();
    check_val("hsk_send_hold", enc_hsk_send_o, 1);
    enc_hsk_done_i = 1'b1;
    #1 check_val("hsk_send_done_cyc", enc_hsk_send_o, 1);
    tick();
    check_val("hsk_send_off", enc_hsk_send_o, 0);
    check_val("hsk_ack", hsk_ack_o, 1);
    check_val("hsk_grant_off", grant_o, 0);
    enc_hsk_done_i = 1'b0;
    hsk_pid_i = PID_NAK;
    gap = 0;
    while (grant_o == 0 && gap < 50) begin
      gap++;
      tick();
    end
    check_val("ipg_gap", gap, 10);
    check_val("ipg_min8", (gap >= 8), 1);
    check_val("hsk2_tuser", m_tuser, 4'hA);
    check_val("hsk_ack_single", hsk_ack_o, 0);
    enc_hsk_done_i = 1'b1;
    tick();
    check_val("hsk2_ack", hsk_ack_o, 1);
    hsk_req_i = 1'b0; enc_hsk_done_i = 1'b0;
    repeat (12) tick();

    // Register write at full speed
    reg_req_i = 1'b1; reg_addr_i = 8'h84; reg_data_i = 8'h45;
    tick();
    check_val("reg_grant", grant_o, 2);
    check_val("reg_write", enc_phy_write_o, 1);
    check_val("reg_addr", enc_phy_addr_o, 8'h84);
    check_val("reg_data", enc_phy_data_o, 8'h45);
    repeat (2) tick();
    check_val("reg_noack_early", reg_ack_o, 0);
    enc_phy_done_i = 1'b1;
    tick();
    check_val("reg_write_off", enc_phy_write_o, 0);
    check_val("reg_ack", reg_ack_o, 1);
    reg_req_i = 1'b0; enc_phy_done_i = 1'b0;
    tick();
    check_val("reg_ack_pulse", reg_ack_o, 0);
    repeat (12) tick();

    // Register write held off while high speed, granted once it drops
    high_speed_i = 1'b1; reg_req_i = 1'b1; reg_addr_i = 8'h0A; reg_data_i = 8'h5C;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (grant_o != 0) seen = 1'b1;
    end
    check_val("reg_hs_blocked", seen, 0);
    high_speed_i = 1'b0;
    tick();
    check_val("reg_hs_released", grant_o, 2);
    check_val("reg_hs_addr", enc_phy_addr_o, 8'h0A);
    enc_phy_done_i = 1'b1;
    tick();
    check_val("reg_hs_ack", reg_ack_o, 1);
    reg_req_i = 1'b0; enc_phy_done_i = 1'b0;
    repeat (12) tick();

    // 4-byte DATA1 packet with m_tready toggling
    done_base = done_cnt;
    beat = 0;
    s_tvalid = 1'b1; s_tkeep = 1'b1; s_tuser = 4'hB; s_tdata = pkt[0]; s_tlast = 1'b0;
    for (int c = 0; c < 40 && beat < 4; c++) begin
      m_tready = c[0];
      #1;
      hs = s_tvalid && s_tready && m_tvalid;
      if (hs) begin
        rx[beat] = m_tdata;
        if (beat == 0) rx_user = m_tuser;
      end
      tick();
      if (hs) begin
        beat++;
        if (beat < 4) begin
          s_tdata = pkt[beat];
          s_tlast = (beat == 3);
        end else begin
          s_tvalid = 1'b0; s_tlast = 1'b0;
        end
      end
    end
    check_val("dat_beats", beat, 4);
    for (int i = 0; i < 4; i++) check_val($sformatf("dat_byte%0d", i), rx[i], pkt[i]);
    check_val("dat_tuser", rx_user, 4'hB);
    check_val("dat_grant", grant_o, 3);
    enc_usb_done_i = 1'b1;
    tick();
    check_val("dat_done", dat_done_o, 1);
    check_val("dat_grant_off", grant_o, 0);
    enc_usb_done_i = 1'b0;
    repeat (12) tick();
    check_val("dat_done_once", done_cnt - done_base, 1);

    // Zero-length packet passes unchanged
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tkeep = 1'b0; s_tlast = 1'b1; s_tuser = 4'h3; s_tdata = 8'h00;
    tick();
    check_val("zdp_pass", {grant_o, m_tvalid, m_tkeep, m_tlast, s_tready, m_tuser}, {2'd3, 4'b1011, 4'h3});
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0; enc_usb_done_i = 1'b1;
    tick();
    check_val("zdp_done", dat_done_o, 1);
    enc_usb_done_i = 1'b0;
    repeat (12) tick();

    // Handshake and data arrive together: handshake wins, data after IPG
    hsk_req_i = 1'b1; hsk_pid_i = PID_STALL;
    s_tvalid = 1'b1; s_tkeep = 1'b1; s_tlast = 1'b1; s_tuser = 4'h3; s_tdata = 8'h55;
    tick();
    check_val("tie_hsk_first", grant_o, 1);
    enc_hsk_done_i = 1'b1;
    tick();
    hsk_req_i = 1'b0; enc_hsk_done_i = 1'b0;
    check_val("tie_hsk_ack", hsk_ack_o, 1);
    #1 check_val("tie_wait_sready", s_tready, 0);
    gap = 0;
    while (grant_o == 0 && gap < 50) begin
      gap++;
      tick();
    end
    check_val("tie_data_next", grant_o, 3);
    check_val("tie_data_byte", m_tdata, 8'h55);
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0; enc_usb_done_i = 1'b1;
    tick();
    check_val("tie_data_done", dat_done_o, 1);
    enc_usb_done_i = 1'b0;
    repeat (12) tick();

    // Watchdog: encoder never reports done, FLUSH drains to tlast
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tkeep = 1'b1; s_tlast = 1'b0; s_tuser = 4'hB; s_tdata = 8'h66;
    tick();
    check_val("wd_grant", grant_o, 3);
    cnt = 0;
    while (!timeout_o && cnt < 1100) begin
      tick();
      cnt++;
    end
    check_val("wd_cycles", cnt, 1023);
    check_val("wd_flush_grant", grant_o, 3);
    check_val("wd_flush_stream", {m_tvalid, s_tready}, 2'b01);
    s_tdata = 8'h67;
    tick();
    check_val("wd_pulse", timeout_o, 0);
    s_tlast = 1'b1;
    check_val("wd_no_done_early", dat_done_o, 0);
    tick();
    check_val("wd_flush_done", dat_done_o, 1);
    check_val("wd_flush_exit", grant_o, 0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (12) tick();

    // Reset during DATA
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tkeep = 1'b1; s_tlast = 1'b0; s_tdata = 8'h77;
    tick();
    check_val("rstd_active", {grant_o, m_tvalid}, 3'b111);
    reset = 1'b1;
    #1;
    check_val("rstd_grant", grant_o, 0);
    check_val("rstd_stream", {m_tvalid, s_tready, m_tdata}, 0);
    tick();
    reset = 1'b0;
    tick();
    check_val("rstd_idle_regrant", grant_o, 3);
    s_tvalid = 1'b0; enc_usb_done_i = 1'b1;
    tick();
    check_val("rstd_done", dat_done_o, 1);
    enc_usb_done_i = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
